data_lp_rx_ctl: RTL and testbench
=================================

DATA_LP_RX_CTL -- requirements
Module: data_lp_rx_ctl

Interface
REQ-001 clk  in  1  lane LP/escape sampling clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; low forces reset values immediately.
REQ-003 Enable  in  1  lane enable; low forces state OFF at the next edge.
REQ-004 LP_Dp, LP_Dn  in  1 each  LP receiver outputs, already synchronous to clk; {LP_Dp,LP_Dn} is the raw line state.
REQ-005 StopState  out  1  high while in STOP.
REQ-006 HS_RX_EN  out  1  high while in HS_RX; enables the HS deserializer.
REQ-007 RxLpdtEsc  out  1  high while in LPDT.
REQ-008 RxDataEsc  out  8  last complete LPDT byte; held until the next byte completes.
REQ-009 RxValidEsc  out  1  one-cycle pulse per completed LPDT byte.
REQ-010 RxUlpsEsc  out  1  high while in ULPS.
REQ-011 UlpsActiveNot  out  1  low while in ULPS, high otherwise.
REQ-012 RxTriggerEsc  out  4  one-hot, one-cycle pulse on a decoded trigger command.
REQ-013 ErrEsc, ErrSyncEsc, ErrControl  out  1 each  one-cycle error pulses.

Function
REQ-014 Line filter: the accepted state ls updates to the raw state only when two consecutive samples agree and differ from ls; ls resets to 2'b11.
REQ-015 All transitions below act on ls changes; all outputs are registered, asserted one cycle after the ls change that causes them.
REQ-016 States: OFF, STOP, HS_RQST, HS_RX, LP_RQST, LP_YIELD, ESC_RQST, ESC_CMD, LPDT, TRIG_WAIT, ULPS, ULPS_EXIT, ERR_WAIT.
REQ-017 OFF -> STOP when Enable=1 and ls=11.
REQ-018 STOP: ls=01 -> HS_RQST; ls=10 -> LP_RQST; ls=00 -> ERR_WAIT with ErrControl.
REQ-019 HS_RQST: ls=00 -> HS_RX; HS_RX: ls=11 -> STOP.
REQ-020 LP_RQST: ls=00 -> LP_YIELD; LP_YIELD: ls=01 -> ESC_RQST; ls=10 (turnaround, unsupported) -> ERR_WAIT with ErrControl.
REQ-021 ESC_RQST: ls=00 -> ESC_CMD with bit counter cleared.
REQ-022 Spaced one-hot bits in ESC_CMD/LPDT: ls=10 is bit 1, ls=01 is bit 0, each mark must follow ls=00; a mark directly followed by the other mark -> ERR_WAIT with ErrControl.
REQ-023 ESC_CMD: bits shift MSB-first (first bit lands in bit 7); the 8th mark decodes the command.
REQ-024 Commands: 8'hE1 -> LPDT; 8'h1E -> ULPS; 8'h62/5D/21/A0 -> TRIG_WAIT with RxTriggerEsc 4'b0001/0010/0100/1000; any other value -> ERR_WAIT with ErrEsc.
REQ-025 LPDT: bits assemble LSB-first; on the 8th mark, RxDataEsc updates and RxValidEsc pulses; the 3-bit counter wraps to 0.
REQ-026 LPDT: ls=11 -> STOP; if the bit counter is nonzero, ErrSyncEsc pulses in the same cycle.
REQ-027 TRIG_WAIT: marks are ignored; ls=11 -> STOP.
REQ-028 ULPS: ls=10 -> ULPS_EXIT; ls=11 -> STOP with ErrControl.
REQ-029 ULPS_EXIT: ls=11 -> STOP; ls=00 -> ULPS.
REQ-030 In LP_RQST, LP_YIELD, ESC_RQST, ESC_CMD and ERR_WAIT: ls=11 -> STOP; ESC_CMD with partial bits also pulses ErrSyncEsc.
REQ-031 Enable=0 has priority over every line event; same cycle ls change is discarded.

Reset
REQ-032 Reset values: state OFF; StopState, HS_RX_EN, RxLpdtEsc, RxValidEsc, RxUlpsEsc, RxTriggerEsc, all Err* = 0; UlpsActiveNot=1; RxDataEsc=8'h00.
REQ-033 Reset asserted mid-LPDT or mid-ULPS: outputs return to reset values immediately with no error pulse; after release, STOP is re-entered only after ls=11 with Enable=1.

Verification
REQ-034 Raw line 11 (3 cycles) with Enable=1 -> StopState=1 within 3 cycles.
REQ-035 11->01->00, each held 4 cycles -> HS_RX_EN=1; then 11 -> HS_RX_EN=0, StopState=1.
REQ-036 Escape entry, command E1, bytes A5 and 3C, then 11 -> RxLpdtEsc=1; RxValidEsc pulses twice with RxDataEsc=8'hA5 then 8'h3C; no errors.
REQ-037 Escape entry, command 62 -> RxTriggerEsc=4'b0001 for 1 cycle; command FF -> ErrEsc pulse, then ERR_WAIT until 11.
REQ-038 Escape entry, ULPS command -> RxUlpsEsc=1, UlpsActiveNot=0; then 10 then 11 -> UlpsActiveNot=1, StopState=1.
REQ-039 LPDT, 5 bits then 11 -> ErrSyncEsc pulse; single-cycle raw glitch to 00 in STOP -> no transition; rst low mid-LPDT -> reset values.

Source files
------------

// File: rtl/data_lp_rx_ctl_if.sv
// Lane-side signal bundle for the LP/escape receive controller.
// slave: the controller (consumes line/enable, drives status and escape data).
// master: whatever drives the line and consumes the escape-mode outputs.
interface data_lp_rx_ctl_if;
    logic       Enable;
    logic       LP_Dp;
    logic       LP_Dn;
    logic       StopState;
    logic       HS_RX_EN;
    logic       RxLpdtEsc;
    logic [7:0] RxDataEsc;
    logic       RxValidEsc;
    logic       RxUlpsEsc;
    logic       UlpsActiveNot;
    logic [3:0] RxTriggerEsc;
    logic       ErrEsc;
    logic       ErrSyncEsc;
    logic       ErrControl;

    modport slave (
        input  Enable, LP_Dp, LP_Dn,
        output StopState, HS_RX_EN, RxLpdtEsc, RxDataEsc, RxValidEsc,
               RxUlpsEsc, UlpsActiveNot, RxTriggerEsc,
               ErrEsc, ErrSyncEsc, ErrControl
    );

    modport master (
        output Enable, LP_Dp, LP_Dn,
        input  StopState, HS_RX_EN, RxLpdtEsc, RxDataEsc, RxValidEsc,
               RxUlpsEsc, UlpsActiveNot, RxTriggerEsc,
               ErrEsc, ErrSyncEsc, ErrControl
    );
endinterface

// File: rtl/data_lp_rx_ctl.sv
// Data lane LP receive controller: filters the raw LP line state, tracks the
// STOP / HS request / escape-mode protocol and decodes escape commands,
// LPDT bytes, ULPS and triggers. All outputs are registered.
module data_lp_rx_ctl (
    input  logic             clk,
    input  logic             rst,
    data_lp_rx_ctl_if.slave  lp
);

    localparam logic [1:0] LS_00 = 2'b00;
    localparam logic [1:0] LS_01 = 2'b01;
    localparam logic [1:0] LS_10 = 2'b10;
    localparam logic [1:0] LS_11 = 2'b11;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_STOP,
        ST_HS_RQST,
        ST_HS_RX,
        ST_LP_RQST,
        ST_LP_YIELD,
        ST_ESC_RQST,
        ST_ESC_CMD,
        ST_LPDT,
        ST_TRIG_WAIT,
        ST_ULPS,
        ST_ULPS_EXIT,
        ST_ERR_WAIT
    } state_t;

    logic [1:0] raw;

    // line filter state
    logic [1:0] raw_prev_q, raw_prev_d;
    logic [1:0] ls_q, ls_d;
    logic [1:0] ls_prev_q, ls_prev_d;
    logic       ls_evt_q, ls_evt_d;

    // protocol state
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;

    // registered outputs
    logic       stop_q, stop_d;
    logic       hs_en_q, hs_en_d;
    logic       lpdt_q, lpdt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ulps_q, ulps_d;
    logic       uan_q, uan_d;
    logic [3:0] trig_q, trig_d;
    logic       err_esc_q, err_esc_d;
    logic       err_sync_q, err_sync_d;
    logic       err_ctl_q, err_ctl_d;

    // decode helpers for the current accepted line state
    logic       is_mark;
    logic       mark_bit;
    logic       spaced;
    logic [7:0] cmd_word;
    logic [7:0] lpdt_word;

    assign raw = {lp.LP_Dp, lp.LP_Dn};

    // Accept a new line state only after two agreeing samples that differ from the current one.
    always_comb begin
        raw_prev_d = raw;
        ls_d       = ls_q;
        ls_prev_d  = ls_prev_q;
        ls_evt_d   = 1'b0;
        if ((raw == raw_prev_q) && (raw != ls_q)) begin
            ls_d      = raw;
            ls_prev_d = ls_q;
            ls_evt_d  = 1'b1;
        end
    end

    // A mark is a valid bit only when the line passed through 00 just before it.
    always_comb begin
        is_mark   = (ls_q == LS_10) || (ls_q == LS_01);
        mark_bit  = (ls_q == LS_10);
        spaced    = (ls_prev_q == LS_00);
        cmd_word  = {shreg_q[6:0], mark_bit};
        lpdt_word = {mark_bit, shreg_q[7:1]};
    end

    // Next-state, bit assembly and output computation for the lane protocol.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        trig_d     = 4'b0000;
        err_esc_d  = 1'b0;
        err_sync_d = 1'b0;
        err_ctl_d  = 1'b0;

        if (!lp.Enable) begin
            // disable wins over any line event seen this cycle
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (ls_q == LS_11) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_01) begin
                            state_d = ST_HS_RQST;
                        end else if (ls_q == LS_10) begin
                            state_d = ST_LP_RQST;
                        end else if (ls_q == LS_00) begin
                            state_d   = ST_ERR_WAIT;
                            err_ctl_d = 1'b1;
                        end
                    end
                end
                ST_HS_RQST: begin
                    // a return to 11 abandons the HS request
                    if (ls_evt_q) begin
                        if (ls_q == LS_00)      state_d = ST_HS_RX;
                        else if (ls_q == LS_11) state_d = ST_STOP;
                    end
                end
                ST_HS_RX: begin
                    if (ls_evt_q && (ls_q == LS_11)) state_d = ST_STOP;
                end
                ST_LP_RQST: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_00)      state_d = ST_LP_YIELD;
                        else if (ls_q == LS_11) state_d = ST_STOP;
                    end
                end
                ST_LP_YIELD: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_01) begin
                            state_d = ST_ESC_RQST;
                        end else if (ls_q == LS_10) begin
                            // bus turnaround is not supported on this lane
                            state_d   = ST_ERR_WAIT;
                            err_ctl_d = 1'b1;
                        end else if (ls_q == LS_11) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_ESC_RQST: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_00) begin
                            state_d   = ST_ESC_CMD;
                            bit_cnt_d = 3'd0;
                            shreg_d   = 8'h00;
                        end else if (ls_q == LS_11) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_ESC_CMD: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_11) begin
                            state_d    = ST_STOP;
                            err_sync_d = (bit_cnt_q != 3'd0);
                        end else if (is_mark && !spaced) begin
                            state_d   = ST_ERR_WAIT;
                            err_ctl_d = 1'b1;
                        end else if (is_mark) begin
                            shreg_d   = cmd_word;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (cmd_word)
                                    8'hE1: state_d = ST_LPDT;
                                    8'h1E: state_d = ST_ULPS;
                                    8'h62: begin state_d = ST_TRIG_WAIT; trig_d = 4'b0001; end
                                    8'h5D: begin state_d = ST_TRIG_WAIT; trig_d = 4'b0010; end
                                    8'h21: begin state_d = ST_TRIG_WAIT; trig_d = 4'b0100; end
                                    8'hA0: begin state_d = ST_TRIG_WAIT; trig_d = 4'b1000; end
                                    default: begin
                                        state_d   = ST_ERR_WAIT;
                                        err_esc_d = 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                end
                ST_LPDT: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_11) begin
                            state_d    = ST_STOP;
                            err_sync_d = (bit_cnt_q != 3'd0);
                        end else if (is_mark && !spaced) begin
                            state_d   = ST_ERR_WAIT;
                            err_ctl_d = 1'b1;
                        end else if (is_mark) begin
                            // counter wraps to 0 after the eighth bit
                            shreg_d   = lpdt_word;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_d  = lpdt_word;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                ST_TRIG_WAIT: begin
                    if (ls_evt_q && (ls_q == LS_11)) state_d = ST_STOP;
                end
                ST_ULPS: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_10) begin
                            state_d = ST_ULPS_EXIT;
                        end else if (ls_q == LS_11) begin
                            state_d   = ST_STOP;
                            err_ctl_d = 1'b1;
                        end
                    end
                end
                ST_ULPS_EXIT: begin
                    if (ls_evt_q) begin
                        if (ls_q == LS_11)      state_d = ST_STOP;
                        else if (ls_q == LS_00) state_d = ST_ULPS;
                    end
                end
                ST_ERR_WAIT: begin
                    if (ls_evt_q && (ls_q == LS_11)) state_d = ST_STOP;
                end
                default: state_d = ST_OFF;
            endcase
        end

        stop_d  = (state_d == ST_STOP);
        hs_en_d = (state_d == ST_HS_RX);
        lpdt_d  = (state_d == ST_LPDT);
        ulps_d  = (state_d == ST_ULPS);
        uan_d   = (state_d != ST_ULPS);
    end

    // Register filter, protocol state and all outputs; reset returns everything to idle values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_prev_q <= LS_11;
            ls_q       <= LS_11;
            ls_prev_q  <= LS_11;
            ls_evt_q   <= 1'b0;
            state_q    <= ST_OFF;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            stop_q     <= 1'b0;
            hs_en_q    <= 1'b0;
            lpdt_q     <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ulps_q     <= 1'b0;
            uan_q      <= 1'b1;
            trig_q     <= 4'b0000;
            err_esc_q  <= 1'b0;
            err_sync_q <= 1'b0;
            err_ctl_q  <= 1'b0;
        end else begin
            raw_prev_q <= raw_prev_d;
            ls_q       <= ls_d;
            ls_prev_q  <= ls_prev_d;
            ls_evt_q   <= ls_evt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            stop_q     <= stop_d;
            hs_en_q    <= hs_en_d;
            lpdt_q     <= lpdt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ulps_q     <= ulps_d;
            uan_q      <= uan_d;
            trig_q     <= trig_d;
            err_esc_q  <= err_esc_d;
            err_sync_q <= err_sync_d;
            err_ctl_q  <= err_ctl_d;
        end
    end

    assign lp.StopState     = stop_q;
    assign lp.HS_RX_EN      = hs_en_q;
    assign lp.RxLpdtEsc     = lpdt_q;
    assign lp.RxDataEsc     = data_q;
    assign lp.RxValidEsc    = valid_q;
    assign lp.RxUlpsEsc     = ulps_q;
    assign lp.UlpsActiveNot = uan_q;
    assign lp.RxTriggerEsc  = trig_q;
    assign lp.ErrEsc        = err_esc_q;
    assign lp.ErrSyncEsc    = err_sync_q;
    assign lp.ErrControl    = err_ctl_q;

endmodule

// File: tb/tb_data_lp_rx_ctl.sv
// Directed bench for data_lp_rx_ctl: a table of line states with expected
// level outputs, followed by hand-written sequences for pulses and reset.
module tb_data_lp_rx_ctl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_lp_rx_ctl_if bus();

    data_lp_rx_ctl dut (
        .clk (clk),
        .rst (rst),
        .lp  (bus)
    );

    // level outputs packed as {StopState, HS_RX_EN, RxLpdtEsc, RxUlpsEsc, UlpsActiveNot}
    localparam logic [4:0] E_IDLE = 5'b00001;
    localparam logic [4:0] E_STOP = 5'b10001;
    localparam logic [4:0] E_HS   = 5'b01001;
    localparam logic [4:0] E_LPDT = 5'b00101;
    localparam logic [4:0] E_ULPS = 5'b00010;

    typedef struct {
        logic       en;
        logic [1:0] raw;
        int         cyc;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    int checks   = 0;
    int failures = 0;

    int         n_valid = 0;
    int         n_esc   = 0;
    int         n_sync  = 0;
    int         n_ctl   = 0;
    int         n_trig  = 0;
    logic [3:0] trig_last = 4'b0000;
    logic [7:0] data_log[$];

    // pulse monitor: counts every cycle each pulse output is high
    always @(negedge clk) begin
        if (bus.RxValidEsc) begin
            n_valid++;
            data_log.push_back(bus.RxDataEsc);
        end
        if (bus.ErrEsc)     n_esc++;
        if (bus.ErrSyncEsc) n_sync++;
        if (bus.ErrControl) n_ctl++;
        if (bus.RxTriggerEsc != 4'b0000) begin
            n_trig++;
            trig_last = bus.RxTriggerEsc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] lvl();
        return {bus.StopState, bus.HS_RX_EN, bus.RxLpdtEsc, bus.RxUlpsEsc, bus.UlpsActiveNot};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] raw, input int cyc);
        bus.Enable = en;
        {bus.LP_Dp, bus.LP_Dn} = raw;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send_esc_entry();
        drive(1'b1, 2'b10, 4);
        drive(1'b1, 2'b00, 4);
        drive(1'b1, 2'b01, 4);
        drive(1'b1, 2'b00, 4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic msb);
        logic bt;
        for (int i = 0; i < n; i++) begin
            bt = msb ? b[7-i] : b[i];
            drive(1'b1, bt ? 2'b10 : 2'b01, 4);
            drive(1'b1, 2'b00, 4);
        end
    endtask

    function automatic void push(input logic en, input logic [1:0] raw, input int cyc, input logic [4:0] exp);
        vec_t v;
        v.en  = en;
        v.raw = raw;
        v.cyc = cyc;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    function automatic void push_esc_entry();
        push(1'b1, 2'b10, 4, E_IDLE);
        push(1'b1, 2'b00, 4, E_IDLE);
        push(1'b1, 2'b01, 4, E_IDLE);
        push(1'b1, 2'b00, 4, E_IDLE);
    endfunction

    function automatic void push_byte(input logic [7:0] b, input logic msb,
                                      input logic [4:0] mid, input logic [4:0] last);
        logic bt;
        for (int i = 0; i < 8; i++) begin
            bt = msb ? b[7-i] : b[i];
            push(1'b1, bt ? 2'b10 : 2'b01, 4, (i == 7) ? last : mid);
            push(1'b1, 2'b00, 4, (i == 7) ? last : mid);
        end
    endfunction

    initial begin
        int t0, e0, s0, v0, c0, sum0;

        // HS burst, then a one-cycle 00 glitch in STOP
        push(1'b1, 2'b11, 3, E_STOP);
        push(1'b1, 2'b01, 4, E_IDLE);
        push(1'b1, 2'b00, 4, E_HS);
        push(1'b1, 2'b11, 4, E_STOP);
        push(1'b1, 2'b00, 1, E_STOP);
        push(1'b1, 2'b11, 4, E_STOP);
        // ULPS entry and exit
        push_esc_entry();
        push_byte(8'h1E, 1'b1, E_IDLE, E_ULPS);
        push(1'b1, 2'b10, 4, E_IDLE);
        push(1'b1, 2'b11, 4, E_STOP);
        // Enable low forces OFF, re-enable returns to STOP
        push(1'b0, 2'b11, 2, E_IDLE);
        push(1'b1, 2'b11, 2, E_STOP);
        // LPDT with two bytes
        push_esc_entry();
        push_byte(8'hE1, 1'b1, E_IDLE, E_LPDT);
        push_byte(8'hA5, 1'b0, E_LPDT, E_LPDT);
        push_byte(8'h3C, 1'b0, E_LPDT, E_LPDT);
        push(1'b1, 2'b11, 4, E_STOP);

        // reset state
        bus.Enable = 1'b0;
        {bus.LP_Dp, bus.LP_Dn} = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_levels", lvl(), E_IDLE);
        check("reset_data", bus.RxDataEsc, 8'h00);
        check("reset_trig", bus.RxTriggerEsc, 4'b0000);
        check("reset_valid", bus.RxValidEsc, 1'b0);
        check("reset_errs", {bus.ErrEsc, bus.ErrSyncEsc, bus.ErrControl}, 3'b000);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].raw, tbl[i].cyc);
            check($sformatf("row%0d", i), lvl(), tbl[i].exp);
        end

        check("lpdt_valid_count", n_valid, 2);
        check("lpdt_byte0", (data_log.size() > 0) ? data_log[0] : 8'hxx, 8'hA5);
        check("lpdt_byte1", (data_log.size() > 1) ? data_log[1] : 8'hxx, 8'h3C);
        check("lpdt_data_held", bus.RxDataEsc, 8'h3C);
        check("table_no_errors", n_esc + n_sync + n_ctl, 0);
        check("table_no_trig", n_trig, 0);

        // trigger command 62
        t0 = n_trig;
        send_esc_entry();
        send_bits(8'h62, 8, 1'b1);
        check("trig_cycles", n_trig - t0, 1);
        check("trig_value", trig_last, 4'b0001);
        drive(1'b1, 2'b11, 4);
        check("trig_to_stop", lvl(), E_STOP);

        // unknown command FF
        e0 = n_esc;
        send_esc_entry();
        send_bits(8'hFF, 8, 1'b1);
        check("bad_cmd_erresc", n_esc - e0, 1);
        drive(1'b1, 2'b00, 4);
        check("err_wait_holds", lvl(), E_IDLE);
        drive(1'b1, 2'b11, 4);
        check("err_wait_to_stop", lvl(), E_STOP);

        // LPDT aborted after 5 bits
        s0 = n_sync;
        v0 = n_valid;
        send_esc_entry();
        send_bits(8'hE1, 8, 1'b1);
        send_bits(8'h0B, 5, 1'b0);
        drive(1'b1, 2'b11, 4);
        check("partial_errsync", n_sync - s0, 1);
        check("partial_no_valid", n_valid - v0, 0);
        check("partial_to_stop", lvl(), E_STOP);

        // 00 straight out of STOP
        c0 = n_ctl;
        drive(1'b1, 2'b00, 4);
        check("stop_00_errctl", n_ctl - c0, 1);
        check("stop_00_levels", lvl(), E_IDLE);
        drive(1'b1, 2'b11, 4);

        // mark directly followed by the opposite mark in LPDT
        c0 = n_ctl;
        send_esc_entry();
        send_bits(8'hE1, 8, 1'b1);
        drive(1'b1, 2'b10, 4);
        drive(1'b1, 2'b01, 4);
        check("unspaced_errctl", n_ctl - c0, 1);
        drive(1'b1, 2'b11, 4);
        check("unspaced_to_stop", lvl(), E_STOP);

        // reset asserted mid-LPDT
        send_esc_entry();
        send_bits(8'hE1, 8, 1'b1);
        send_bits(8'h05, 3, 1'b0);
        check("pre_reset_lpdt", lvl(), E_LPDT);
        sum0 = n_esc + n_sync + n_ctl;
        #2 rst = 1'b0;
        #1;
        check("midrst_levels", lvl(), E_IDLE);
        check("midrst_data", bus.RxDataEsc, 8'h00);
        bus.Enable = 1'b1;
        {bus.LP_Dp, bus.LP_Dn} = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        check("midrst_no_err", n_esc + n_sync + n_ctl, sum0);
        rst = 1'b1;
        drive(1'b1, 2'b11, 2);
        check("post_rst_stop", lvl(), E_STOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
